// File: rtl/transducer_pwm.sv
// Per-transducer ultrasound PWM drive: samples duty/phase once per period,
// optionally slews them, and emits a phase-centred pulse locked to TIME.
module transducer_pwm #(
    parameter int unsigned CYCLE = 640
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [9:0] TIME,
    input  logic [7:0] DUTY,
    input  logic [7:0] PHASE,
    input  logic       SILENT,
    output logic       PWM_OUT
);

    localparam logic [9:0]  CYC   = 10'(CYCLE);
    localparam logic [9:0]  LAST  = 10'(CYCLE - 1);
    localparam logic [10:0] CYC_W = 11'(CYCLE);

    logic [7:0]  duty_tgt;
    logic [7:0]  phase_tgt;
    logic [7:0]  duty_cur;
    logic [7:0]  phase_cur;
    logic [9:0]  w_s;
    logic [9:0]  c_s;
    logic [9:0]  rise_p;
    logic [9:0]  fall_p;
    logic        w0_p;
    logic        vld_p;
    logic [9:0]  rise;
    logic [9:0]  fall;
    logic        w0;
    logic        live;

    logic [7:0]  duty_nx;
    logic [7:0]  phase_nx;
    logic [7:0]  phase_dlt;
    logic [9:0]  w_n;
    logic [9:0]  c_n;
    logic [9:0]  half;
    logic [9:0]  rise_n;
    logic [10:0] fall_sum;
    logic [9:0]  fall_n;
    logic        hi;

    assign phase_dlt = phase_tgt - phase_cur;

    always_comb begin
        duty_nx  = duty_tgt;
        phase_nx = phase_tgt;
        if (SILENT) begin
            duty_nx  = duty_cur;
            phase_nx = phase_cur;
            if (duty_cur < duty_tgt)
                duty_nx = duty_cur + 8'd1;
            else if (duty_cur > duty_tgt)
                duty_nx = duty_cur - 8'd1;
            // a half-turn tie resolves downward
            if (phase_dlt != 8'd0)
                phase_nx = phase_dlt[7] ? phase_cur - 8'd1
                                        : phase_cur + 8'd1;
        end
    end

    assign w_n  = 10'((18'(duty_cur) * 18'(CYC)) >> 9);
    assign c_n  = 10'((18'(phase_cur) * 18'(CYC)) >> 8);
    assign half = w_s >> 1;

    always_comb begin
        if (c_s >= half)
            rise_n = c_s - half;
        else
            rise_n = 10'(11'(c_s) + CYC_W - 11'(half));
        fall_sum = 11'(rise_n) + 11'(w_s);
        if (fall_sum >= CYC_W)
            fall_n = 10'(fall_sum - CYC_W);
        else
            fall_n = fall_sum[9:0];
    end

    // live stays low until a fully computed edge set has been committed
    always_comb begin
        hi = 1'b0;
        if (live && !w0) begin
            if (rise < fall)
                hi = (TIME >= rise) && (TIME < fall);
            else
                hi = (TIME >= rise) || (TIME < fall);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            duty_tgt  <= '0;
            phase_tgt <= '0;
            duty_cur  <= '0;
            phase_cur <= '0;
            w_s       <= '0;
            c_s       <= '0;
            rise_p    <= '0;
            fall_p    <= '0;
            w0_p      <= 1'b0;
            vld_p     <= 1'b0;
            rise      <= '0;
            fall      <= '0;
            w0        <= 1'b0;
            live      <= 1'b0;
            PWM_OUT   <= 1'b0;
        end else begin
            PWM_OUT <= hi;
            case (TIME)
                LAST: begin
                    duty_tgt  <= DUTY;
                    phase_tgt <= PHASE;
                    rise      <= rise_p;
                    fall      <= fall_p;
                    w0        <= w0_p;
                    live      <= vld_p;
                end
                10'd0: begin
                    duty_cur  <= duty_nx;
                    phase_cur <= phase_nx;
                end
                10'd1: begin
                    w_s <= w_n;
                    c_s <= c_n;
                end
                10'd2: begin
                    rise_p <= rise_n;
                    fall_p <= fall_n;
                    w0_p   <= (w_s == 10'd0);
                    vld_p  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_transducer_pwm.sv
// Bench for transducer_pwm: per-period waveform scoreboard against a
// centre-offset reference model plus fixed-pattern checks.
module tb_transducer_pwm;

    localparam int CYC = 640;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [9:0] TIME = '0;
    logic [7:0] DUTY = '0;
    logic [7:0] PHASE = '0;
    logic       SILENT = 1'b0;
    logic       PWM_OUT;

    int checks = 0;
    int errors = 0;

    logic [CYC-1:0] exp_q[$];

    int m_dt, m_pt, m_dc, m_pc, m_cd, m_cp, m_arm, m_pv;

    transducer_pwm #(.CYCLE(CYC)) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .TIME(TIME),
        .DUTY(DUTY),
        .PHASE(PHASE),
        .SILENT(SILENT),
        .PWM_OUT(PWM_OUT)
    );

    always #5 CLK = ~CLK;

    // high when t lies within W clocks starting W/2 before the centre
    function automatic logic model_hi(input int t);
        int w, c, h;
        w = (m_cd * CYC) / 512;
        c = (m_cp * CYC) / 256;
        h = w / 2;
        if (m_arm == 0 || w == 0) return 1'b0;
        return ((t - c + h + CYC) % CYC) < w;
    endfunction

    task automatic model_reset();
        m_dt = 0; m_pt = 0; m_dc = 0; m_pc = 0;
        m_cd = 0; m_cp = 0; m_arm = 0; m_pv = 0;
    endtask

    task automatic model_slew(input logic s);
        int d;
        if (!s) begin
            m_dc = m_dt;
            m_pc = m_pt;
        end else begin
            if (m_dc < m_dt) m_dc++;
            else if (m_dc > m_dt) m_dc--;
            d = (m_pt - m_pc + 256) % 256;
            if (d >= 1 && d <= 127) m_pc = (m_pc + 1) % 256;
            else if (d >= 128) m_pc = (m_pc + 255) % 256;
        end
        m_pv = 1;
    endtask

    task automatic run_period(input int d, input int p, input logic s,
                              output logic [CYC-1:0] obs,
                              output logic [CYC-1:0] expv);
        logic [CYC-1:0] e;
        DUTY = 8'(d);
        PHASE = 8'(p);
        SILENT = s;
        model_slew(s);
        for (int t = 0; t < CYC; t++) e[t] = model_hi(t);
        exp_q.push_back(e);
        for (int t = 0; t < CYC; t++) begin
            TIME = 10'(t);
            @(posedge CLK);
            #1;
            obs[t] = PWM_OUT;
        end
        m_cd = m_dc; m_cp = m_pc; m_arm = m_pv;
        m_dt = d; m_pt = p;
        expv = exp_q.pop_front();
    endtask

    function automatic logic [CYC-1:0] range_mask(input int lo, input int hi,
                                                   input logic wrap);
        logic [CYC-1:0] m;
        for (int t = 0; t < CYC; t++)
            m[t] = wrap ? (t >= lo || t < hi) : (t >= lo && t < hi);
        return m;
    endfunction

    task automatic test_reset();
        logic [CYC-1:0] obs, expv;
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (PWM_OUT !== 1'b0) begin
            errors++;
            $display("FAIL reset_out got=%b want=0", PWM_OUT);
        end
        RST_N = 1'b1;
        model_reset();
        run_period(200, 40, 1'b0, obs, expv);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_first_period ones=%0d want=0", $countones(obs));
        end
    endtask

    task automatic test_full_duty();
        logic [CYC-1:0] obs, expv;
        for (int i = 0; i < 3; i++) begin
            run_period(255, 0, 1'b0, obs, expv);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL full_sb[%0d] got=%h want=%h", i, obs, expv);
            end
        end
        checks++;
        if (obs !== range_mask(481, 159, 1'b1) || $countones(obs) != 318) begin
            errors++;
            $display("FAIL full_pattern ones=%0d want=318 got=%h", $countones(obs), obs);
        end
    endtask

    task automatic test_mid();
        logic [CYC-1:0] obs, expv;
        for (int i = 0; i < 3; i++) begin
            run_period(128, 128, 1'b0, obs, expv);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL mid_sb[%0d] got=%h want=%h", i, obs, expv);
            end
        end
        checks++;
        if (obs !== range_mask(240, 400, 1'b0)) begin
            errors++;
            $display("FAIL mid_pattern ones=%0d want=160 got=%h", $countones(obs), obs);
        end
    endtask

    task automatic test_zero_duty();
        logic [CYC-1:0] obs, expv;
        int want[4] = '{318, 318, 0, 0};
        for (int i = 0; i < 3; i++) run_period(255, 0, 1'b0, obs, expv);
        for (int i = 0; i < 4; i++) begin
            run_period(0, 77, 1'b0, obs, expv);
            checks++;
            if ($countones(obs) != want[i] || obs !== expv) begin
                errors++;
                $display("FAIL zero_duty[%0d] ones=%0d want=%0d", i, $countones(obs), want[i]);
            end
        end
    endtask

    task automatic test_silent_duty();
        logic [CYC-1:0] obs, expv;
        int want[14] = '{0, 0, 1, 2, 3, 5, 6, 7, 8, 10, 11, 12, 12, 12};
        run_period(0, 0, 1'b0, obs, expv);
        run_period(0, 0, 1'b0, obs, expv);
        for (int i = 0; i < 14; i++) begin
            run_period(10, 0, 1'b1, obs, expv);
            checks++;
            if ($countones(obs) != want[i] || obs !== expv) begin
                errors++;
                $display("FAIL silent_duty[%0d] ones=%0d want=%0d", i, $countones(obs), want[i]);
            end
        end
    endtask

    task automatic test_silent_phase();
        logic [CYC-1:0] obs, expv;
        run_period(128, 250, 1'b0, obs, expv);
        run_period(128, 5, 1'b0, obs, expv);
        for (int i = 0; i < 13; i++) begin
            run_period(128, 5, 1'b1, obs, expv);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL phase_sb[%0d] got=%h want=%h", i, obs, expv);
            end
            if (i == 6) begin
                checks++;
                if (obs !== range_mask(560, 80, 1'b1)) begin
                    errors++;
                    $display("FAIL phase_at_zero got=%h", obs);
                end
            end
            if (i >= 11) begin
                checks++;
                if (obs !== range_mask(572, 92, 1'b1)) begin
                    errors++;
                    $display("FAIL phase_at_five[%0d] got=%h", i, obs);
                end
            end
        end
    endtask

    task automatic test_phase_tie();
        logic [CYC-1:0] obs, expv;
        run_period(128, 250, 1'b0, obs, expv);
        run_period(128, 122, 1'b0, obs, expv);
        run_period(128, 122, 1'b1, obs, expv);
        run_period(128, 122, 1'b1, obs, expv);
        checks++;
        if (obs !== range_mask(542, 62, 1'b1) || obs !== expv) begin
            errors++;
            $display("FAIL phase_tie rise542=%b rise541=%b want 1/0", obs[542], obs[541]);
        end
    endtask

    task automatic test_mid_reset();
        logic [CYC-1:0] obs, expv;
        bit tail_ok;
        for (int i = 0; i < 3; i++) run_period(128, 128, 1'b0, obs, expv);
        DUTY = 8'd255;
        PHASE = 8'd0;
        SILENT = 1'b0;
        for (int t = 0; t <= 300; t++) begin
            TIME = 10'(t);
            @(posedge CLK);
            #1;
        end
        checks++;
        if (PWM_OUT !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_high got=%b want=1", PWM_OUT);
        end
        TIME = 10'd301;
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if (PWM_OUT !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_drop got=%b want=0", PWM_OUT);
        end
        #1 RST_N = 1'b1;
        model_reset();
        tail_ok = 1'b1;
        for (int t = 301; t < CYC; t++) begin
            TIME = 10'(t);
            @(posedge CLK);
            #1;
            if (PWM_OUT !== 1'b0) tail_ok = 1'b0;
        end
        m_cd = m_dc; m_cp = m_pc; m_arm = m_pv;
        m_dt = 255; m_pt = 0;
        checks++;
        if (!tail_ok) begin
            errors++;
            $display("FAIL reset_tail got=high want=low");
        end
        run_period(255, 0, 1'b0, obs, expv);
        checks++;
        if (obs !== '0 || obs !== expv) begin
            errors++;
            $display("FAIL reset_period1 ones=%0d want=0", $countones(obs));
        end
        run_period(255, 0, 1'b0, obs, expv);
        checks++;
        if (obs !== range_mask(481, 159, 1'b1) || obs !== expv) begin
            errors++;
            $display("FAIL reset_period2 ones=%0d want=318", $countones(obs));
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_duty();
        test_mid();
        test_zero_duty();
        test_silent_duty();
        test_silent_phase();
        test_phase_tie();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
